serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial N-bit subtractor computing x − y − bin one bit per clock, LSB first, with a per-bit borrow vector and signed overflow flag. It is the inverse-direction companion to the team's N-bit ripple-carry adder. It trades the adder's combinational carry chain for a single registered full-subtractor cell iterated by a small state machine. It sits beside the adder in the ALU datapath. A controller issues `start` and collects the result on `done`.

## Interface
- `N`, default 8: operand width. Minimum legal value is 2. The counter is ceil(log2(N)) bits wide.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE.
- `x` input N: minuend, captured when `start` is accepted.
- `y` input N: subtrahend, captured when `start` is accepted.
- `bin` input 1: borrow-in, captured when `start` is accepted.
- `diff` output N: result register.
- `borrow` output N: borrow out of each bit position. `borrow[i]` is the borrow out of bit i.
- `overflow` output 1: signed overflow, `borrow[N-1]` XOR `borrow[N-2]`.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle pulse in DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE to RUN on `start` = 1:
  - Capture x, y, bin into internal shift registers.
  - Clear `diff` and `borrow`.
  - Set bit counter to 0.
- RUN, each cycle, processes bit i = counter:
  - d = x_i ^ y_i ^ b. Shift d into `diff` at position i.
  - b_next = (~x_i & y_i) | (~(x_i ^ y_i) & b). Write b_next to `borrow[i]` and the internal borrow register.
  - b is `bin` for i = 0.
  - Increment the counter. After bit N−1, go to DONE.
- DONE:
  - `overflow` is valid.
  - `done` = 1 for exactly one cycle, then the block returns to IDLE unconditionally.
- `start` in RUN or DONE is ignored. There is no queuing.
- `diff`, `borrow` and `overflow` hold their values from DONE until the next accepted `start`.
- Arithmetic is modulo 2^N. `borrow[N-1]` is the unsigned borrow-out: 1 means x < y + bin unsigned.

## Timing
- Reset: state IDLE, `diff` = 0, `borrow` = 0, `overflow` = 0, `busy` = 0, `done` = 0, counter 0.
- Reset asserted in any state, including mid-RUN, takes effect at the next edge. The partial result is discarded and no `done` is issued.
- `start` sampled high at edge E:
  - `busy` = 1 from E through E+N.
  - Bits 0..N−1 are written at edges E+1..E+N.
  - `done` = 1 in the cycle after edge E+N.
  - Total latency is N+1 cycles; 9 for N = 8.
- Back-to-back operation: the earliest next accepted `start` is the edge after DONE, E+N+2. The throughput is one operation per N+2 cycles.
- `busy` and `done` are never high together.
- `start` held high continuously restarts on every IDLE cycle.

## Configuration
- `SERIAL_SUB_SAT_EN` defined:
  - On entry to DONE with overflow = 1, `diff` is replaced by the signed limit.
  - If x[N-1] = 0, the limit is 2^(N-1)−1 (0x7F).
  - If x[N-1] = 1, the limit is −2^(N-1) (0x80).
  - `borrow` and `overflow` are unchanged. Latency is unchanged.
- `SERIAL_SUB_SAT_EN` undefined: `diff` is the raw wrapped result. There is no saturation logic.

## Test plan
- Reset during RUN after 3 bits (x=0x55, y=0x0F) -> next cycle all outputs 0, state IDLE, no `done` pulse.
- x=0x05, y=0x03, bin=0 -> `done` 9 cycles after `start`, diff=0x02, borrow=0x02, overflow=0.
- x=0x80, y=0x01, bin=0 -> diff=0x7F (0x80 with SAT_EN), borrow=0x7F, overflow=1.
- x=0x7F, y=0xFF, bin=0 -> diff=0x80 (0x7F with SAT_EN), borrow=0x80, overflow=1.
- x=0x00, y=0x00, bin=1 -> diff=0xFF, borrow=0xFF, overflow=0.
- Protocol check:
  - Pulse `start` with new operands at cycles 2, 5 and 9 after an accepted `start` -> all ignored, result matches the first operands.
  - `start` at E+10 -> accepted.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor (x - y - bin), LSB first, one full-subtractor step per clock.
// Optional macro SERIAL_SUB_SAT_EN clamps diff to the signed limit on overflow.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         bin,
  output logic [N-1:0] diff,
  output logic [N-1:0] borrow,
  output logic         overflow,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg;
  logic [N-1:0]  x_sh_reg;
  logic [N-1:0]  y_sh_reg;
  logic          b_reg;
  logic [CW-1:0] cnt_reg;
`ifdef SERIAL_SUB_SAT_EN
  logic          x_msb_reg;
`endif

  logic          xi;
  logic          yi;
  logic          d_next;
  logic          b_next;
  logic          ovf_next;
  logic [N-1:0]  diff_next;
  logic [N-1:0]  borrow_next;

  // The operand registers shift right, so the current bit is always at index 0.
  assign xi       = x_sh_reg[0];
  assign yi       = y_sh_reg[0];
  assign d_next   = xi ^ yi ^ b_reg;
  assign b_next   = (~xi & yi) | (~(xi ^ yi) & b_reg);
  assign ovf_next = b_next ^ borrow[N-2];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      assign diff_next[gi]   = (cnt_reg == CW'(gi)) ? d_next : diff[gi];
      assign borrow_next[gi] = (cnt_reg == CW'(gi)) ? b_next : borrow[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      x_sh_reg  <= '0;
      y_sh_reg  <= '0;
      b_reg     <= 1'b0;
      cnt_reg   <= '0;
      diff      <= '0;
      borrow    <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SERIAL_SUB_SAT_EN
      x_msb_reg <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            x_sh_reg  <= x;
            y_sh_reg  <= y;
            b_reg     <= bin;
            cnt_reg   <= '0;
            diff      <= '0;
            borrow    <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b1;
            state_reg <= RUN;
`ifdef SERIAL_SUB_SAT_EN
            x_msb_reg <= x[N-1];
`endif
          end
        end
        RUN: begin
          x_sh_reg <= {1'b0, x_sh_reg[N-1:1]};
          y_sh_reg <= {1'b0, y_sh_reg[N-1:1]};
          b_reg    <= b_next;
          diff     <= diff_next;
          borrow   <= borrow_next;
          if (cnt_reg == LAST) begin
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            overflow  <= ovf_next;
            state_reg <= DONE;
`ifdef SERIAL_SUB_SAT_EN
            // Overrides the raw result written above when the signed result wrapped.
            if (ovf_next) begin
              diff <= x_msb_reg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
            end
`endif
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: scoreboard of expected results, one task per scenario.
module tb_serial_subtractor;
  localparam int N  = 8;
  localparam int TO = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         bin;
  logic [N-1:0] diff;
  logic [N-1:0] borrow;
  logic         overflow;
  logic         busy;
  logic         done;

  typedef struct packed {
    logic [N-1:0] d;
    logic [N-1:0] b;
    logic         o;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .bin(bin),
    .diff(diff), .borrow(borrow), .overflow(overflow), .busy(busy), .done(done)
  );

  // Reference: borrow[i] is whether the low i+1 bits of x are below those of y plus bin.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] s, input logic c);
    exp_t e;
    int   mask;
    int   r;
    for (int i = 0; i < N; i++) begin
      mask = (1 << (i + 1)) - 1;
      e.b[i] = (int'(a) & mask) < ((int'(s) & mask) + int'(c));
    end
    r   = int'($signed(a)) - int'($signed(s)) - int'(c);
    e.o = (r > (2 ** (N - 1)) - 1) || (r < -(2 ** (N - 1)));
    e.d = a - s - {{(N-1){1'b0}}, c};
`ifdef SERIAL_SUB_SAT_EN
    if (e.o) e.d = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
    return e;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] s, input logic c);
    x = a; y = s; bin = c; start = 1'b1;
    sb_q.push_back(model(a, s, c));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit overlap);
    cyc = 0;
    overlap = 1'b0;
    while (!done && cyc < TO) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (busy && done) overlap = 1'b1;
    end
  endtask

  task automatic test_reset();
    int dcnt;
    rst = 1'b1; start = 1'b0; x = '0; y = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({diff, borrow, overflow, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got diff=%h borrow=%h ovf=%b busy=%b done=%b expected all 0",
               diff, borrow, overflow, busy, done);
    end
    issue(8'h55, 8'h0F, 1'b0);
    void'(sb_q.pop_back());
    repeat (3) begin @(posedge clk); @(negedge clk); end
    n_cmp++;
    if ({busy, diff, borrow} !== {1'b1, 8'h06, 8'h06}) begin
      n_err++;
      $display("FAIL partial_run: got busy=%b diff=%h borrow=%h expected busy=1 diff=06 borrow=06",
               busy, diff, borrow);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({diff, borrow, overflow, busy, done} !== '0) begin
      n_err++;
      $display("FAIL midrun_reset: got diff=%h borrow=%h ovf=%b busy=%b done=%b expected all 0",
               diff, borrow, overflow, busy, done);
    end
    dcnt = 0;
    repeat (12) begin
      @(posedge clk); @(negedge clk);
      if (done || busy) dcnt++;
    end
    n_cmp++;
    if (dcnt !== 0) begin
      n_err++;
      $display("FAIL abort_no_done: got %0d busy/done cycles expected 0", dcnt);
    end
    $display("reset: mid-run reset x=55 y=0f checked");
  endtask

  task automatic test_vectors();
    logic [N-1:0] va[10];
    logic [N-1:0] vb[10];
    logic         vc[10];
    int           cyc;
    bit           ovl;
    exp_t         e;
    va[0] = 8'h05; vb[0] = 8'h03; vc[0] = 1'b0;
    va[1] = 8'h80; vb[1] = 8'h01; vc[1] = 1'b0;
    va[2] = 8'h7F; vb[2] = 8'hFF; vc[2] = 1'b0;
    va[3] = 8'h00; vb[3] = 8'h00; vc[3] = 1'b1;
    for (int i = 4; i < 10; i++) begin
      va[i] = N'($urandom); vb[i] = N'($urandom); vc[i] = 1'($urandom);
    end
    for (int i = 0; i < 10; i++) begin
      issue(va[i], vb[i], vc[i]);
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_err++;
        $display("FAIL busy_after_start: got busy=%b done=%b expected busy=1 done=0", busy, done);
      end
      wait_done(cyc, ovl);
      n_cmp++;
      if (cyc !== N || done !== 1'b1 || ovl) begin
        n_err++;
        $display("FAIL done_timing: got done=%b after %0d cycles overlap=%b expected done=1 after %0d overlap=0",
                 done, cyc, ovl, N);
      end
      e = sb_q.pop_front();
      n_cmp++;
      if ({diff, borrow, overflow} !== e) begin
        n_err++;
        $display("FAIL result: got diff=%h borrow=%h ovf=%b expected diff=%h borrow=%h ovf=%b",
                 diff, borrow, overflow, e.d, e.b, e.o);
      end
      $display("op x=%h y=%h bin=%b -> diff=%h borrow=%h ovf=%b", va[i], vb[i], vc[i], diff, borrow, overflow);
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if ({done, busy, diff, borrow, overflow} !== {2'b00, e}) begin
        n_err++;
        $display("FAIL hold_after_done: got done=%b busy=%b diff=%h borrow=%h ovf=%b expected done=0 busy=0 diff=%h borrow=%h ovf=%b",
                 done, busy, diff, borrow, overflow, e.d, e.b, e.o);
      end
    end
  endtask

  task automatic test_protocol();
    int   dcnt;
    int   cyc;
    bit   ovl;
    bit   seen;
    exp_t e;
    issue(8'h5A, 8'h3C, 1'b0);
    dcnt = 0;
    seen = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      start = (c == 2 || c == 5 || c == 9);
      x = N'($urandom); y = N'($urandom); bin = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        dcnt++;
        if (c == N) seen = 1'b1;
      end
      if (done && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({diff, borrow, overflow} !== e) begin
          n_err++;
          $display("FAIL ignored_start_result: got diff=%h borrow=%h ovf=%b expected diff=%h borrow=%h ovf=%b",
                   diff, borrow, overflow, e.d, e.b, e.o);
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (dcnt !== 1 || !seen || busy !== 1'b0) begin
      n_err++;
      $display("FAIL ignored_start_protocol: got %0d done pulses (on time=%b) busy=%b expected 1 on time, busy=0",
               dcnt, seen, busy);
    end
    $display("protocol: x=5a y=3c with starts at E+2,E+5,E+9 -> diff=%h", diff);
    issue(8'h10, 8'h20, 1'b1);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL start_at_e10: got busy=%b expected 1", busy);
    end
    wait_done(cyc, ovl);
    e = sb_q.pop_front();
    n_cmp++;
    if (cyc !== N || {diff, borrow, overflow} !== e) begin
      n_err++;
      $display("FAIL e10_result: got diff=%h borrow=%h ovf=%b after %0d expected diff=%h borrow=%h ovf=%b after %0d",
               diff, borrow, overflow, cyc, e.d, e.b, e.o, N);
    end
    $display("op x=10 y=20 bin=1 -> diff=%h borrow=%h ovf=%b", diff, borrow, overflow);
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int           t;
    int           last;
    int           guard;
    exp_t         e;
    logic [N-1:0] a;
    logic [N-1:0] s;
    logic         c;
    a = N'($urandom); s = N'($urandom); c = 1'($urandom);
    x = a; y = s; bin = c; start = 1'b1;
    sb_q.push_back(model(a, s, c));
    t = 0;
    last = -1;
    for (int k = 0; k < 4; k++) begin
      guard = 0;
      do begin
        @(posedge clk); t++; guard++;
        @(negedge clk);
      end while (!done && guard < TO);
      e = sb_q.pop_front();
      n_cmp++;
      if (done !== 1'b1 || {diff, borrow, overflow} !== e) begin
        n_err++;
        $display("FAIL b2b_result: got done=%b diff=%h borrow=%h ovf=%b expected done=1 diff=%h borrow=%h ovf=%b",
                 done, diff, borrow, overflow, e.d, e.b, e.o);
      end
      if (last >= 0) begin
        n_cmp++;
        if (t - last !== N + 2) begin
          n_err++;
          $display("FAIL b2b_spacing: got %0d cycles between done pulses expected %0d", t - last, N + 2);
        end
      end
      $display("b2b op x=%h y=%h bin=%b -> diff=%h borrow=%h ovf=%b", a, s, c, diff, borrow, overflow);
      last = t;
      if (k < 3) begin
        a = N'($urandom); s = N'($urandom); c = 1'($urandom);
        x = a; y = s; bin = c;
        sb_q.push_back(model(a, s, c));
      end else begin
        start = 1'b0;
      end
    end
    repeat (2) begin @(posedge clk); @(negedge clk); end
    n_cmp++;
    if (busy !== 1'b0 || sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL b2b_idle: got busy=%b queue=%0d expected busy=0 queue=0", busy, sb_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_vectors();
    test_protocol();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
